fft_frame_collector: RTL and testbench

FFT_FRAME_COLLECTOR -- requirements
Module: fft_frame_collector

---
 rtl/fft_frame_collector_pkg.sv | 33 +++
 rtl/fft_frame_bank.sv | 28 ++
 rtl/fft_frame_collector.sv | 184 ++++++++++++++++++
 tb/tb_fft_frame_collector.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_frame_collector_pkg.sv
`default_nettype none
// ============================================================================
// fft_frame_collector_pkg : shared defaults, FSM encodings and bit-reverse helper
// Revision 1.0
// ============================================================================
package fft_frame_collector_pkg;

  localparam int FFT_N_DEFAULT  = 256;
  localparam int FFT_DW_DEFAULT = 16;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_FILL = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_PRIME = 2'd1,
    RD_OUT   = 2'd2
  } rd_state_t;

  // Reverses the low 'bits' bits of idx; upper result bits are zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] idx, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r[5'(i)] = idx[5'(bits - 1 - i)];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_frame_bank.sv
`default_nettype none
// ============================================================================
// fft_frame_bank : N x 2*DW simple dual-port RAM, 1-cycle registered read
// Revision 1.0
// ============================================================================
module fft_frame_bank
  import fft_frame_collector_pkg::*;
#(
  parameter int N  = FFT_N_DEFAULT,
  parameter int DW = FFT_DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] waddr,
  input  logic [2*DW-1:0]      wdata,
  input  logic [$clog2(N)-1:0] raddr,
  output logic [2*DW-1:0]      rdata
);

  logic [2*DW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/fft_frame_collector.sv
`default_nettype none
// ============================================================================
// fft_frame_collector : ping-pong frame buffer between FFT output and a
// ready/valid reader. FFT_COLLECT_BITREV_EN stores samples at bit-reversed
// addresses.   Revision 1.0
// ============================================================================
module fft_frame_collector
  import fft_frame_collector_pkg::*;
#(
  parameter int N  = FFT_N_DEFAULT,
  parameter int DW = FFT_DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic          sop_in,
  input  logic [DW-1:0] x_re,
  input  logic [DW-1:0] x_im,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_sop,
  output logic          m_eop,
  output logic [DW-1:0] m_re,
  output logic [DW-1:0] m_im,
  output logic          ovf,
  output logic          sop_err
);

  localparam int            AW   = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  wr_state_t     r_wr_state, w_wr_state_n;
  logic [AW-1:0] r_wr_cnt, w_wr_cnt_n, w_wr_idx, w_waddr;
  logic          r_wr_bank, w_wr_bank_n, w_we;
  logic [1:0]    r_full, w_set, w_clr;
  logic          r_ovf, w_ovf_n, r_sop_err, w_sop_err_n;

  rd_state_t     r_rd_state, w_rd_state_n;
  logic          r_rd_bank, w_rd_bank_n, r_out_bank, w_out_bank_n;
  logic [AW-1:0] r_rd_idx, w_rd_idx_n, w_raddr;
  logic [2*DW-1:0] w_rdata [2];
  logic [2*DW-1:0] w_rd_word;

  // A bank being released by the reader this cycle may be reused at once.
  logic w_tgt_full;
  assign w_tgt_full = r_full[r_wr_bank] && !w_clr[r_wr_bank];

  always_comb begin
    w_wr_state_n = r_wr_state;
    w_wr_cnt_n   = r_wr_cnt;
    w_wr_bank_n  = r_wr_bank;
    w_we         = 1'b0;
    w_wr_idx     = '0;
    w_set        = 2'b00;
    w_ovf_n      = 1'b0;
    w_sop_err_n  = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        if (valid_in && sop_in) begin
          if (w_tgt_full) begin
            w_ovf_n = 1'b1;
          end else begin
            w_we         = 1'b1;
            w_wr_cnt_n   = AW'(1);
            w_wr_state_n = WR_FILL;
          end
        end
      end
      WR_FILL: begin
        if (valid_in) begin
          w_we = 1'b1;
          if (sop_in) begin
            w_sop_err_n = 1'b1;
            w_wr_cnt_n  = AW'(1);
          end else begin
            w_wr_idx = r_wr_cnt;
            if (r_wr_cnt == LAST) begin
              w_set[r_wr_bank] = 1'b1;
              w_wr_bank_n      = ~r_wr_bank;
              w_wr_cnt_n       = '0;
              w_wr_state_n     = WR_IDLE;
            end else begin
              w_wr_cnt_n = r_wr_cnt + AW'(1);
            end
          end
        end
      end
      default: w_wr_state_n = WR_IDLE;
    endcase
  end

`ifdef FFT_COLLECT_BITREV_EN
  assign w_waddr = AW'(bit_reverse(32'(w_wr_idx), AW));
`else
  assign w_waddr = w_wr_idx;
`endif

  // Read side: PRIME issues address 0, OUT presents data and re-reads the
  // displayed address while stalled so the RAM output holds steady.
  always_comb begin
    w_rd_state_n = r_rd_state;
    w_rd_bank_n  = r_rd_bank;
    w_rd_idx_n   = r_rd_idx;
    w_out_bank_n = r_out_bank;
    w_raddr      = r_rd_idx;
    w_clr        = 2'b00;
    case (r_rd_state)
      RD_IDLE: begin
        w_raddr = '0;
        if (r_full[r_rd_bank]) w_rd_state_n = RD_PRIME;
      end
      RD_PRIME: begin
        w_raddr      = '0;
        w_rd_idx_n   = '0;
        w_out_bank_n = r_rd_bank;
        w_rd_state_n = RD_OUT;
      end
      RD_OUT: begin
        if (m_ready) begin
          if (r_rd_idx == LAST) begin
            w_clr[r_rd_bank] = 1'b1;
            w_rd_bank_n      = ~r_rd_bank;
            w_rd_idx_n       = '0;
            w_raddr          = '0;
            if (r_full[~r_rd_bank]) w_out_bank_n = ~r_rd_bank;
            else                    w_rd_state_n = RD_IDLE;
          end else begin
            w_raddr    = r_rd_idx + AW'(1);
            w_rd_idx_n = r_rd_idx + AW'(1);
          end
        end
      end
      default: w_rd_state_n = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= WR_IDLE;
      r_wr_cnt   <= '0;
      r_wr_bank  <= 1'b0;
      r_full     <= 2'b00;
      r_ovf      <= 1'b0;
      r_sop_err  <= 1'b0;
      r_rd_state <= RD_IDLE;
      r_rd_bank  <= 1'b0;
      r_rd_idx   <= '0;
      r_out_bank <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_n;
      r_wr_cnt   <= w_wr_cnt_n;
      r_wr_bank  <= w_wr_bank_n;
      r_full     <= (r_full | w_set) & ~w_clr;
      r_ovf      <= w_ovf_n;
      r_sop_err  <= w_sop_err_n;
      r_rd_state <= w_rd_state_n;
      r_rd_bank  <= w_rd_bank_n;
      r_rd_idx   <= w_rd_idx_n;
      r_out_bank <= w_out_bank_n;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(.N(N), .DW(DW)) u_bank (
      .clk   (clk),
      .we    (w_we && (r_wr_bank == 1'(b))),
      .waddr (w_waddr),
      .wdata ({x_re, x_im}),
      .raddr (w_raddr),
      .rdata (w_rdata[b])
    );
  end

  assign w_rd_word = w_rdata[r_out_bank];
  assign m_valid   = (r_rd_state == RD_OUT);
  assign m_sop     = m_valid && (r_rd_idx == '0);
  assign m_eop     = m_valid && (r_rd_idx == LAST);
  assign m_re      = m_valid ? w_rd_word[2*DW-1:DW] : '0;
  assign m_im      = m_valid ? w_rd_word[DW-1:0]    : '0;
  assign ovf       = r_ovf;
  assign sop_err   = r_sop_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_collector.sv
`default_nettype none
// ============================================================================
// tb_fft_frame_collector : directed table-driven bench for fft_frame_collector
// Revision 1.0
// ============================================================================
module tb_fft_frame_collector;

  localparam int N  = 256;
  localparam int DW = 16;
`ifdef FFT_COLLECT_BITREV_EN
  localparam bit BITREV = 1'b1;
`else
  localparam bit BITREV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic          sop_in = 1'b0;
  logic [DW-1:0] x_re = '0;
  logic [DW-1:0] x_im = '0;
  logic          m_valid, m_sop, m_eop, ovf, sop_err;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_re, m_im;

  fft_frame_collector #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sop_in(sop_in),
    .x_re(x_re), .x_im(x_im), .m_valid(m_valid), .m_ready(m_ready),
    .m_sop(m_sop), .m_eop(m_eop), .m_re(m_re), .m_im(m_im),
    .ovf(ovf), .sop_err(sop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sop;
    logic          eop;
    int            cyc;
  } beat_t;

  typedef struct {
    int base;
    int rmode;
    bit gap;
    int e_re0;
    int e_re1;
    int e_re255;
    int e_im1;
  } vec_t;

  beat_t rx[$];
  int    checks = 0, errors = 0;
  int    ready_mode = 0;
  int    cyc = 0, stall_viol = 0, ovf_cnt = 0, sop_err_cnt = 0;
  logic  prev_stall = 1'b0;
  logic [2*DW+2:0] prev_bus = '0;
  vec_t  tv[4];

  always @(posedge clk) cyc <= cyc + 1;

  // Collects accepted beats and watches output stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && ({m_valid, m_sop, m_eop, m_re, m_im} !== prev_bus)) stall_viol++;
      prev_stall = m_valid && !m_ready;
      prev_bus   = {m_valid, m_sop, m_eop, m_re, m_im};
      if (m_valid && m_ready) rx.push_back('{re: m_re, im: m_im, sop: m_sop, eop: m_eop, cyc: cyc});
      if (ovf) ovf_cnt++;
      if (sop_err) sop_err_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = ~m_ready;
    endcase
  endtask

  function automatic int exp_idx(input int k);
    logic [7:0] kk, rr;
    kk = 8'(k);
    for (int b = 0; b < 8; b++) rr[b] = kk[7 - b];
    return BITREV ? int'(rr) : k;
  endfunction

  task automatic send_frame(input int base, input int count, input bit gap);
    for (int i = 0; i < count; i++) begin
      valid_in = 1'b1;
      sop_in   = (i == 0);
      x_re     = 16'(base - i);
      x_im     = 16'(-(base - i));
      step();
      if (gap && (i % 7 == 3) && (i < N - 1)) begin
        valid_in = 1'b0;
        sop_in   = 1'b0;
        step();
      end
    end
    valid_in = 1'b0;
    sop_in   = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t = 0;
    while (rx.size() < n && t < budget) begin
      step();
      t++;
    end
    check("rx_count_reached", 32'(rx.size() >= n), 1);
  endtask

  task automatic verify_frame(input int base);
    int bad = 0, fbad = 0, idx;
    if (rx.size() < N) begin
      check("frame_avail", rx.size(), N);
      rx.delete();
      return;
    end
    for (int k = 0; k < N; k++) begin
      idx = exp_idx(k);
      if (rx[k].re !== 16'(base - idx) || rx[k].im !== 16'(-(base - idx))) bad++;
      if (rx[k].sop !== (k == 0) || rx[k].eop !== (k == N - 1)) fbad++;
    end
    check("frame_data", bad, 0);
    check("frame_sop_eop", fbad, 0);
    repeat (N) void'(rx.pop_front());
  endtask

  initial begin
    tv[0] = '{256, 1, 1'b0, 256,  BITREV ? 128  : 255,  1,    BITREV ? -128 : -255};
    tv[1] = '{256, 2, 1'b0, 256,  BITREV ? 128  : 255,  1,    BITREV ? -128 : -255};
    tv[2] = '{1000, 1, 1'b1, 1000, BITREV ? 872  : 999,  745,  BITREV ? -872 : -999};
    tv[3] = '{-5, 2, 1'b1, -5,    BITREV ? -133 : -6,   -260, BITREV ? 133  : 6};

    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", 32'({m_valid, m_sop, m_eop, ovf, sop_err}), 0);
    check("reset_data", 32'({m_re, m_im}), 0);
    rst = 1'b0;
    step();

    for (int r = 0; r < 4; r++) begin
      ready_mode = tv[r].rmode;
      stall_viol = 0;
      send_frame(tv[r].base, N, tv[r].gap);
      step();
      check("latency_edge1", 32'(m_valid), 0);
      step();
      check("latency_edge2", 32'(m_valid), 1);
      wait_rx(N, 1500);
      if (rx.size() >= N) begin
        check("row_re0", 32'($signed(rx[0].re)), tv[r].e_re0);
        check("row_re1", 32'($signed(rx[1].re)), tv[r].e_re1);
        check("row_re255", 32'($signed(rx[255].re)), tv[r].e_re255);
        check("row_im1", 32'($signed(rx[1].im)), tv[r].e_im1);
      end
      verify_frame(tv[r].base);
      check("stall_stable", stall_viol, 0);
      repeat (4) step();
    end

    // Three back-to-back frames against a stalled reader.
    ovf_cnt = 0;
    ready_mode = 0;
    m_ready = 1'b0;
    send_frame(100, N, 1'b0);
    send_frame(200, N, 1'b0);
    send_frame(300, N, 1'b0);
    repeat (3) step();
    check("ovf_once", ovf_cnt, 1);
    check("held_valid", 32'(m_valid), 1);
    check("held_no_rx", rx.size(), 0);
    ready_mode = 1;
    wait_rx(2 * N, 2000);
    if (rx.size() >= 2 * N) check("no_bubble", rx[N].cyc - rx[N-1].cyc, 1);
    verify_frame(100);
    verify_frame(200);
    repeat (300) step();
    check("third_dropped", rx.size(), 0);

    // sop mid-frame restarts the frame.
    sop_err_cnt = 0;
    ovf_cnt = 0;
    send_frame(500, 100, 1'b0);
    send_frame(700, N, 1'b0);
    wait_rx(N, 1000);
    check("sop_err_once", sop_err_cnt, 1);
    verify_frame(700);
    repeat (300) step();
    check("partial_dropped", rx.size(), 0);
    check("no_ovf_restart", ovf_cnt, 0);

    // Bank release and new sop on the same edge.
    ready_mode = 0;
    m_ready = 1'b0;
    send_frame(2000, N, 1'b0);
    send_frame(3000, N, 1'b0);
    ready_mode = 1;
    m_ready = 1'b1;
    repeat (N - 1) step();
    send_frame(4000, N, 1'b0);
    wait_rx(3 * N, 3000);
    check("same_cycle_no_ovf", ovf_cnt, 0);
    verify_frame(2000);
    verify_frame(3000);
    verify_frame(4000);

    // Reset during readout.
    repeat (4) step();
    send_frame(600, N, 1'b0);
    wait_rx(50, 1000);
    rst = 1'b1;
    step();
    check("rst_mid_valid", 32'({m_valid, m_sop, m_eop, ovf, sop_err}), 0);
    check("rst_mid_data", 32'({m_re, m_im}), 0);
    rst = 1'b0;
    rx.delete();
    repeat (2) step();
    check("post_rst_idle", 32'(m_valid), 0);
    send_frame(900, N, 1'b0);
    wait_rx(N, 1000);
    verify_frame(900);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
